cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache controller.
- Sits between the MEM stage and the SRAM controller.
- Accepts 32-bit word requests from MEM and issues 64-bit line fills and 32-bit write-throughs to the SRAM controller.
- Returns `ready` to MEM, which freezes the pipeline while `ready` is low.

Parameters:
- INDEX_W, 6, set index width; 2^INDEX_W sets.
- TAG_W, 10, stored tag width.
- ADDR_OFFSET, 32'd1024, subtracted from the incoming address before decoding.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- address  in  32  MEM byte address.
- wdata  in  32  MEM store data.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- rdata  out  32  load data.
- ready  out  1  request complete / pipeline may advance.
- sram_address  out  32  address to the SRAM controller (offset-removed).
- sram_wdata  out  32  write-through data.
- sram_r_en  out  1  line-fill request.
- sram_w_en  out  1  write-through request.
- sram_rdata  in  64  fill line.
- sram_ready  in  1  SRAM controller done.

Behaviour:
- Address decode on `a = address - ADDR_OFFSET`:
  - word select: `a[2]`
  - index: `a[INDEX_W+2:3]`
  - tag: `a[INDEX_W+TAG_W+2:INDEX_W+3]`
- Per set: 2 ways, each holding valid, tag, and 64-bit data. One LRU bit per set, pointing at the victim way.
  - Access to way0 sets LRU=1; access to way1 sets LRU=0.
  - Victim choice: way0 if invalid, else way1 if invalid, else the way named by LRU.
- Reset:
  - state=IDLE; all valid bits=0; all LRU bits=0.
  - sram_r_en=0, sram_w_en=0, rdata=0.
  - ready=1 (no request pending).
- MEM holds address, wdata and enables stable while ready=0. If MEM_R_EN and MEM_W_EN are both set, the write wins.
- FSM states: IDLE, FILL, WRITE.
- IDLE, no request: ready=1, SRAM enables 0.
- IDLE, read hit:
  - ready=1 in the same cycle; rdata = hit word, combinational.
  - LRU updated at the clock edge.
  - No SRAM access.
- IDLE, read miss:
  - ready=0; go to FILL.
- FILL:
  - sram_r_en=1; sram_address = `{a[31:3],3'b000}`.
  - While sram_ready=0: ready=0.
  - In the sram_ready=1 cycle:
    - ready=1; rdata = `a[2] ? sram_rdata[63:32] : sram_rdata[31:0]`.
    - Victim way written (valid=1, tag, line); LRU updated.
    - Next state IDLE.
- IDLE, write:
  - ready=0; go to WRITE.
- WRITE:
  - sram_w_en=1; sram_address=a; sram_wdata=wdata.
  - ready = sram_ready.
  - In the sram_ready=1 cycle:
    - On a hit, the selected word in the hit way is updated and LRU updated.
    - On a miss, no cache change.
    - Next state IDLE.
- Miss/write latency: ready rises in the same cycle as sram_ready. SRAM enables drop in the cycle after.
- One SRAM request is outstanding at most; enables are never both 1.
- Reset mid-FILL or mid-WRITE: abort immediately to the reset state. The partial line is not installed.
- Hit is evaluated only in IDLE. A request arriving at the FILL→IDLE edge is treated as new.

Optional Feature:
- CACHE_STATS_EN: when defined, adds `hit_count` out 32 and `miss_count` out 32.
  - Each increments once per completed read (hit in IDLE, miss at fill completion).
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: the ports and counters do not exist. Functional behaviour is identical.

Test Plan:
1. Cold read:
   - Stimulus: after reset, read 1024; SRAM returns 64'h1111_2222_3333_4444 with sram_ready after 5 cycles.
   - Required: ready=0 for 5 cycles; a single request with sram_r_en=1, sram_address=0; rdata=32'h3333_4444 when ready=1.
2. Read hit:
   - Stimulus: read 1028 next.
   - Required: ready=1 in the same cycle; rdata=32'h1111_2222; sram_r_en stays 0.
3. Eviction:
   - Stimulus: read 1024, 1536, 2048 (same set, stride 512), then re-read 1536 and 1024.
   - Required: 2048 evicts 1024; 1536 hits; 1024 misses and issues a FILL.
4. Write hit:
   - Stimulus: write 32'hDEAD_BEEF to 1028 while the line is resident.
   - Required: sram_w_en=1, sram_wdata=32'hDEAD_BEEF until sram_ready. A following read of 1028 hits with rdata=32'hDEAD_BEEF.
5. Write miss:
   - Stimulus: write to 4096, then read 4096.
   - Required: the write completes on sram_ready; the read misses (no allocate).
6. Reset during FILL:
   - Stimulus: assert rst during FILL.
   - Required: sram_r_en=0 asynchronously; ready=1 after release; the same address later misses. With CACHE_STATS_EN, counters read 0.

Source files
------------

// File: rtl/cache_controller_if.sv
// MEM-side request/response and SRAM-controller signals of cache_controller.
// master drives requests and SRAM responses; slave is the cache itself.
interface cache_controller_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_controller #(
    parameter int unsigned INDEX_W     = 6,
    parameter int unsigned TAG_W       = 10,
    parameter logic [31:0] ADDR_OFFSET = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int unsigned SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
    state_t state, state_next;

    logic [31:0]        a;
    logic               word_sel;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;

    assign a        = bus.address - ADDR_OFFSET;
    assign word_sel = a[2];
    assign idx      = a[INDEX_W+2:3];
    assign tag      = a[INDEX_W+TAG_W+2:INDEX_W+3];

    logic [SETS-1:0]  valid [2];
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tag_mem  [2][SETS];
    logic [63:0]      data_mem [2][SETS];

    logic [1:0]  way_hit;
    logic        hit;
    logic        hit_way;
    logic        victim;
    logic [63:0] hit_line;

    assign way_hit[0] = valid[0][idx] && (tag_mem[0][idx] == tag);
    assign way_hit[1] = valid[1][idx] && (tag_mem[1][idx] == tag);
    assign hit        = |way_hit;
    // Only missing lines are ever filled, so at most one way of a set can match.
    assign hit_way    = way_hit[1];
    assign hit_line   = data_mem[hit_way][idx];
    assign victim     = !valid[0][idx] ? 1'b0 :
                        !valid[1][idx] ? 1'b1 : lru[idx];

    logic        line_we;
    logic        lru_we;
    logic        fill_done;
    logic        acc_way;
    logic [63:0] line_new;

    always_comb begin
        state_next       = state;
        bus.ready        = 1'b1;
        bus.rdata        = '0;
        bus.sram_r_en    = 1'b0;
        bus.sram_w_en    = 1'b0;
        bus.sram_address = a;
        bus.sram_wdata   = bus.wdata;
        line_we          = 1'b0;
        lru_we           = 1'b0;
        fill_done        = 1'b0;
        acc_way          = hit_way;
        line_new         = hit_line;

        case (state)
            IDLE: begin
                if (bus.MEM_W_EN) begin
                    bus.ready  = 1'b0;
                    state_next = WRITE;
                end else if (bus.MEM_R_EN) begin
                    if (hit) begin
                        bus.rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
                        lru_we    = 1'b1;
                    end else begin
                        bus.ready  = 1'b0;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                bus.sram_r_en    = 1'b1;
                bus.sram_address = {a[31:3], 3'b000};
                bus.ready        = bus.sram_ready;
                if (bus.sram_ready) begin
                    bus.rdata  = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
                    acc_way    = victim;
                    line_new   = bus.sram_rdata;
                    line_we    = 1'b1;
                    lru_we     = 1'b1;
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                bus.sram_w_en = 1'b1;
                bus.ready     = bus.sram_ready;
                if (bus.sram_ready) begin
                    state_next = IDLE;
                    if (hit) begin
                        line_we  = 1'b1;
                        lru_we   = 1'b1;
                        line_new = word_sel ? {bus.wdata, hit_line[31:0]}
                                            : {hit_line[63:32], bus.wdata};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else begin
            state <= state_next;
            if (fill_done)
                valid[acc_way][idx] <= 1'b1;
            // LRU names the victim, i.e. the way not just touched.
            if (lru_we)
                lru[idx] <= ~acc_way;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we)
            data_mem[acc_way][idx] <= line_new;
        if (fill_done)
            tag_mem[acc_way][idx] <= tag;
    end

`ifdef CACHE_STATS_EN
    logic rd_hit;
    assign rd_hit = (state == IDLE) && !bus.MEM_W_EN && bus.MEM_R_EN && hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit && (hit_count != '1))
                hit_count <= hit_count + 32'd1;
            if (fill_done && (miss_count != '1))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: SRAM responder, transaction-level
// cache model checked every cycle, plus directed literal expectations.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_controller_if bus();
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller #(.INDEX_W(6), .TAG_W(10), .ADDR_OFFSET(32'd1024)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Backing store, keyed by line number (offset-removed address / 8).
    logic [63:0] mem [int unsigned];

    function automatic logic [63:0] line_of(input int unsigned key);
        if (mem.exists(key)) return mem[key];
        return {key ^ 32'h5A5A_0000, key ^ 32'hC3C3_0000};
    endfunction

    // SRAM controller: sram_ready in the sram_lat-th cycle of a request.
    int unsigned sram_lat  = 5;
    int unsigned sram_cnt  = 0;
    int unsigned fill_reqs = 0;
    logic        prev_r_en = 1'b0;
    logic [31:0] last_fill_addr = '1;

    initial begin
        bus.sram_ready = 1'b0;
        bus.sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.sram_r_en && !prev_r_en) begin
                fill_reqs++;
                last_fill_addr = bus.sram_address;
            end
            prev_r_en = bus.sram_r_en;
            if (bus.sram_r_en || bus.sram_w_en) begin
                sram_cnt++;
                if (sram_cnt == sram_lat) begin
                    bus.sram_ready = 1'b1;
                    if (bus.sram_r_en) begin
                        bus.sram_rdata = line_of(bus.sram_address >> 3);
                    end else begin
                        logic [63:0] ln;
                        ln = line_of(bus.sram_address >> 3);
                        if (bus.sram_address[2]) ln[63:32] = bus.sram_wdata;
                        else                     ln[31:0]  = bus.sram_wdata;
                        mem[bus.sram_address >> 3] = ln;
                    end
                end else begin
                    bus.sram_ready = 1'b0;
                    bus.sram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                end
            end else begin
                sram_cnt       = 0;
                bus.sram_ready = 1'b0;
            end
        end
    end

    // Reference cache: transaction-level view of the two-way LRU cache.
    logic        m_valid [2][64];
    logic [9:0]  m_tag   [2][64];
    logic [63:0] m_data  [2][64];
    int unsigned m_lru   [64];
    int unsigned phase    = 0;   // 0 idle, 1 read miss pending, 2 write pending
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;
    logic        checking = 1'b0;

    initial forever begin
        logic [31:0] ma;
        int unsigned idx, tg, wd, key, vw;
        int          hw;
        logic [63:0] ln;
        @(negedge clk);
        #2;
        if (!checking) continue;
        if (!rst) begin
            check("rst_ready", bus.ready, 1);
            check("rst_r_en", bus.sram_r_en, 0);
            check("rst_w_en", bus.sram_w_en, 0);
            check("rst_rdata", bus.rdata, 0);
            for (int s = 0; s < 64; s++) begin
                m_valid[0][s] = 1'b0;
                m_valid[1][s] = 1'b0;
                m_lru[s] = 0;
            end
            phase = 0; m_hits = 0; m_misses = 0;
            continue;
        end
        check("en_exclusive", bus.sram_r_en & bus.sram_w_en, 0);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`endif
        ma  = bus.address - 32'd1024;
        key = ma >> 3;
        idx = key % 64;
        tg  = (ma >> 9) % 1024;
        wd  = (ma >> 2) % 2;
        hw  = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][idx] && m_tag[w][idx] == tg[9:0]) hw = w;
        case (phase)
            0: begin
                if (bus.MEM_W_EN) begin
                    check("wr_start_ready", bus.ready, 0);
                    check("wr_start_en", {bus.sram_r_en, bus.sram_w_en}, 0);
                    phase = 2;
                end else if (bus.MEM_R_EN) begin
                    check("rd_start_en", {bus.sram_r_en, bus.sram_w_en}, 0);
                    if (hw >= 0) begin
                        ln = m_data[hw][idx];
                        check("hit_ready", bus.ready, 1);
                        check("hit_rdata", bus.rdata, wd ? ln[63:32] : ln[31:0]);
                        m_lru[idx] = (hw == 0) ? 1 : 0;
                        m_hits++;
                    end else begin
                        check("miss_ready", bus.ready, 0);
                        phase = 1;
                    end
                end else begin
                    check("idle_ready", bus.ready, 1);
                    check("idle_en", {bus.sram_r_en, bus.sram_w_en}, 0);
                end
            end
            1: begin
                check("fill_r_en", bus.sram_r_en, 1);
                check("fill_w_en", bus.sram_w_en, 0);
                check("fill_addr", bus.sram_address, key << 3);
                check("fill_ready", bus.ready, bus.sram_ready);
                if (bus.sram_ready) begin
                    ln = line_of(key);
                    check("fill_rdata", bus.rdata, wd ? ln[63:32] : ln[31:0]);
                    vw = !m_valid[0][idx] ? 0 : !m_valid[1][idx] ? 1 : m_lru[idx];
                    m_valid[vw][idx] = 1'b1;
                    m_tag[vw][idx]   = tg[9:0];
                    m_data[vw][idx]  = ln;
                    m_lru[idx] = (vw == 0) ? 1 : 0;
                    m_misses++;
                    phase = 0;
                end
            end
            default: begin
                check("wt_w_en", bus.sram_w_en, 1);
                check("wt_r_en", bus.sram_r_en, 0);
                check("wt_addr", bus.sram_address, ma);
                check("wt_wdata", bus.sram_wdata, bus.wdata);
                check("wt_ready", bus.ready, bus.sram_ready);
                if (bus.sram_ready) begin
                    if (hw >= 0) begin
                        if (wd == 1) m_data[hw][idx][63:32] = bus.wdata;
                        else         m_data[hw][idx][31:0]  = bus.wdata;
                        m_lru[idx] = (hw == 0) ? 1 : 0;
                    end
                    phase = 0;
                end
            end
        endcase
    end

    // Hold one request until ready; waits = number of ready-low cycles.
    task automatic do_req(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, output int unsigned waits,
                          output logic [31:0] rd);
        @(negedge clk);
        bus.address  = addr;
        bus.wdata    = data;
        bus.MEM_R_EN = r;
        bus.MEM_W_EN = w;
        waits = 0;
        #2;
        while (!bus.ready && waits < 200) begin
            @(negedge clk);
            #2;
            waits++;
        end
        if (!bus.ready) check("req_timeout", 0, 1);
        rd = bus.rdata;
        @(negedge clk);
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
    endtask

    int unsigned waits;
    logic [31:0] rd;

    initial begin
        bus.address  = '0;
        bus.wdata    = '0;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        mem[0] = 64'h1111_2222_3333_4444;
        #1;
        rst = 1'b0;
        checking = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        do_req(1, 0, 32'd1024, 0, waits, rd);
        check("t1_waits", waits, 5);
        check("t1_rdata", rd, 32'h3333_4444);
        check("t1_fill_reqs", fill_reqs, 1);
        check("t1_fill_addr", last_fill_addr, 0);

        do_req(1, 0, 32'd1028, 0, waits, rd);
        check("t2_waits", waits, 0);
        check("t2_rdata", rd, 32'h1111_2222);
        check("t2_fill_reqs", fill_reqs, 1);

        do_req(1, 0, 32'd1024, 0, waits, rd);
        check("t3_1024_hit", waits, 0);
        do_req(1, 0, 32'd1536, 0, waits, rd);
        check("t3_1536_miss", waits, 5);
        do_req(1, 0, 32'd2048, 0, waits, rd);
        check("t3_2048_miss", waits, 5);
        do_req(1, 0, 32'd1536, 0, waits, rd);
        check("t3_1536_hit", waits, 0);
        check("t3_1536_rdata", rd, 32'hC3C3_0040);
        do_req(1, 0, 32'd1024, 0, waits, rd);
        check("t3_1024_evicted", waits, 5);
        check("t3_fill_reqs", fill_reqs, 4);

        do_req(0, 1, 32'd1028, 32'hDEAD_BEEF, waits, rd);
        check("t4_wr_waits", waits, 5);
        do_req(1, 0, 32'd1028, 0, waits, rd);
        check("t4_rd_hit", waits, 0);
        check("t4_rdata", rd, 32'hDEAD_BEEF);

        do_req(1, 1, 32'd4096, 32'hCAFE_F00D, waits, rd);
        check("t5_wr_waits", waits, 5);
        check("t5_no_allocate_fill", fill_reqs, 4);
        do_req(1, 0, 32'd4096, 0, waits, rd);
        check("t5_rd_miss", waits, 5);
        check("t5_rdata", rd, 32'hCAFE_F00D);
        check("t5_fill_reqs", fill_reqs, 5);

        @(negedge clk);
        bus.address  = 32'd1032;
        bus.MEM_R_EN = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t6_in_fill", bus.sram_r_en, 1);
`ifdef CACHE_STATS_EN
        check("t6_hits_before", hit_count, 4);
        check("t6_misses_before", miss_count, 5);
`endif
        rst = 1'b0;
        bus.MEM_R_EN = 1'b0;
        #1;
        check("t6_abort_r_en", bus.sram_r_en, 0);
`ifdef CACHE_STATS_EN
        check("t6_hits_clr", hit_count, 0);
        check("t6_misses_clr", miss_count, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("t6_ready_after", bus.ready, 1);
        do_req(1, 0, 32'd1032, 0, waits, rd);
        check("t6_same_addr_miss", waits, 5);
        do_req(1, 0, 32'd1028, 0, waits, rd);
        check("t6_invalidated_miss", waits, 5);
        check("t6_rdata", rd, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
